// File: rtl/mem_copy_dma_if.sv
// Bundle for mem_copy_dma: copy request/status from the CPU side and the data-memory pins.
// The master modport is the DMA engine's view; slave is the CPU/memory side.
interface mem_copy_dma_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  start, src_addr, dst_addr, length, mem_read_data,
        output busy, done, checksum, mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        output start, src_addr, dst_addr, length, mem_read_data,
        input  busy, done, checksum, mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-copy initiator: one word per READ/WRITE pair, ascending addresses, modulo-2^ADDR_W wrap.
// Optional running checksum of copied words when MEM_COPY_DMA_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | memory outputs 0, waiting for start
// READ  | mem_read, address = src + i, capture read word
// WRITE | mem_write, address = dst + i, drive captured word
// DONE  | one-cycle done pulse
module mem_copy_dma #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    mem_copy_dma_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_next;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_q;
    logic              wr_q;

    assign idx_next = idx + LEN_W'(1);

    // Outputs are registered alongside the state so each one is a pure Moore decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            data_q <= '0;
            addr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_q <= bus.src_addr;
                        dst_q <= bus.dst_addr;
                        len_q <= bus.length;
                        idx   <= '0;
                        if (bus.length == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= READ;
                            busy_q <= 1'b1;
                            rd_q   <= 1'b1;
                            addr_q <= bus.src_addr;
                        end
                    end
                end
                READ: begin
                    data_q <= bus.mem_read_data;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b1;
                    addr_q <= dst_q + ADDR_W'(idx);
                    state  <= WRITE;
                end
                WRITE: begin
                    idx    <= idx_next;
                    wr_q   <= 1'b0;
                    data_q <= '0;
                    if (idx_next == len_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        addr_q <= '0;
                    end else begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        addr_q <= src_q + ADDR_W'(idx_next);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = data_q;

`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state == IDLE && bus.start) begin
            csum_q <= '0;
        end else if (state == READ) begin
            csum_q <= csum_q + bus.mem_read_data;
        end
    end

    assign bus.checksum = csum_q;
`else
    assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma against a 256-word memory and an ascending-copy reference model.
module tb_mem_copy_dma;
    logic clk = 1'b0;
    logic reset;
    logic load_mem;

    mem_copy_dma_if bus ();

    mem_copy_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory is indexed by the low 8 address bits, so 0xFFFFFFFF and 0 are neighbours.
    logic [31:0] mem      [256];
    logic [31:0] init_mem [256];
    logic [31:0] exp_mem  [256];
    logic [31:0] words    [$];

    always @(posedge clk) begin
        if (load_mem)
            mem <= init_mem;
        else if (bus.mem_write)
            mem[bus.mem_address[7:0]] <= bus.mem_write_data;
    end

    assign bus.mem_read_data = mem[bus.mem_address[7:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic commit_mem();
        load_mem = 1'b1;
        @(posedge clk);
        #1;
        load_mem = 1'b0;
        @(negedge clk);
    endtask

    task automatic randomize_mem();
        for (int j = 0; j < 256; j++) init_mem[j] = $urandom;
        commit_mem();
    endtask

    // mode 0: single start pulse; 1: random start/args during transfer; 2: start held high throughout
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input int mode);
        logic [31:0] a;
        logic [31:0] exp_ck;
        logic [35:0] got, want;
        int k;
        int bad;
        exp_ck = 32'h0;
        words.delete();
        exp_mem = mem;
        for (int j = 0; j < len; j++) begin
            a = src + 32'(j);
            words.push_back(exp_mem[a[7:0]]);
            a = dst + 32'(j);
            exp_mem[a[7:0]] = words[j];
            exp_ck = exp_ck + words[j];
        end
`ifndef MEM_COPY_DMA_CHECKSUM_EN
        exp_ck = 32'h0;
`endif
        bus.start    = 1'b1;
        bus.src_addr = src;
        bus.dst_addr = dst;
        bus.length   = 8'(len);
        @(posedge clk);
        for (int c = 1; c <= 2 * len + 1; c++) begin
            @(negedge clk);
            if (c == 2 * len + 1) begin
                want = {4'b0100, 32'h0};
            end else if (c % 2 == 1) begin
                k = (c - 1) / 2;
                want = {4'b1010, src + 32'(k)};
            end else begin
                k = (c - 2) / 2;
                want = {4'b1001, dst + 32'(k)};
            end
            got = {bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.mem_address};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ctrl len=%0d cycle %0d: {busy,done,rd,wr,addr} got %h want %h", len, c, got, want);
            end
            n_tests++;
            if ((bus.mem_read & bus.mem_write) !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_wr_overlap cycle %0d: rd=%b wr=%b want not both", c, bus.mem_read, bus.mem_write);
            end
            if (c % 2 == 0 && c <= 2 * len) begin
                k = (c - 2) / 2;
                n_tests++;
                if (bus.mem_write_data !== words[k]) begin
                    n_fail++;
                    $display("FAIL wdata word %0d: got %h want %h", k, bus.mem_write_data, words[k]);
                end
            end
            if (mode == 0 || c == 2 * len + 1) begin
                if (mode != 2) bus.start = 1'b0;
            end else if (mode == 1) begin
                bus.start    = 1'($urandom);
                bus.src_addr = $urandom;
                bus.dst_addr = $urandom;
                bus.length   = 8'($urandom);
            end
        end
        n_tests++;
        if (bus.checksum !== exp_ck) begin
            n_fail++;
            $display("FAIL checksum len=%0d: got %h want %h", len, bus.checksum, exp_ck);
        end
        bad = 0;
        for (int j = 0; j < 256; j++) if (mem[j] !== exp_mem[j]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL memory len=%0d: %0d words differ, want 0", len, bad);
        end
        if (mode != 2) begin
            @(negedge clk);
            got = {bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.mem_address};
            n_tests++;
            if (got !== 36'h0 || bus.mem_write_data !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_after_done: got %h wdata %h want 0", got, bus.mem_write_data);
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        load_mem     = 1'b0;
        bus.start    = 1'b0;
        bus.src_addr = 32'h0;
        bus.dst_addr = 32'h0;
        bus.length   = 8'h0;
        for (int j = 0; j < 256; j++) init_mem[j] = $urandom;
        commit_mem();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done, bus.mem_read, bus.mem_write} !== 4'b0 || bus.mem_address !== 32'h0 ||
            bus.mem_write_data !== 32'h0 || bus.checksum !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b addr=%h wd=%h ck=%h want all 0",
                     bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data, bus.checksum);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_copy();
        init_mem = mem;
        for (int j = 0; j < 4; j++) init_mem[j] = 32'd9;
        commit_mem();
        run_copy(32'd0, 32'd8, 4, 0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        n_tests++;
        if (bus.checksum !== 32'd36) begin
            n_fail++;
            $display("FAIL basic_checksum: got %0d want 36", bus.checksum);
        end
`endif
    endtask

    task automatic test_zero_length();
        run_copy(32'd5, 32'd20, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_copy(32'd30, 32'd40, 2, 1);
    endtask

    task automatic test_wrap();
        init_mem = mem;
        init_mem[255] = $urandom;
        init_mem[0]   = $urandom;
        commit_mem();
        run_copy(32'hFFFF_FFFF, 32'd16, 2, 0);
    endtask

    task automatic test_back_to_back();
        run_copy(32'd50, 32'd70, 3, 2);
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done, bus.mem_read, bus.mem_write} !== 4'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: {busy,done,rd,wr} got %b want 0000",
                     {bus.busy, bus.done, bus.mem_read, bus.mem_write});
        end
        run_copy(32'd90, 32'd100, 2, 0);
    endtask

    task automatic test_reset_abort();
        logic seen_done;
        int bad;
        randomize_mem();
        exp_mem = init_mem;
        exp_mem[8] = init_mem[0];
        bus.start    = 1'b1;
        bus.src_addr = 32'd0;
        bus.dst_addr = 32'd8;
        bus.length   = 8'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL abort_cycle3: rd=%b addr=%h want rd=1 addr=1", bus.mem_read, bus.mem_address);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done, bus.mem_read, bus.mem_write} !== 4'b0 || bus.mem_address !== 32'h0 ||
            bus.mem_write_data !== 32'h0 || bus.checksum !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b rd=%b wr=%b addr=%h wd=%h ck=%h want all 0",
                     bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data, bus.checksum);
        end
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done/busy seen after reset, got 1 want 0");
        end
        bad = 0;
        for (int j = 0; j < 256; j++) if (mem[j] !== exp_mem[j]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_memory: %0d words differ, want 0 (mem[8]=%h want %h)", bad, mem[8], exp_mem[8]);
        end
    endtask

    task automatic test_random();
        logic [31:0] src, dst;
        int len;
        randomize_mem();
        for (int it = 0; it < 10; it++) begin
            src = 32'($urandom_range(3, 200));
            if (it % 2 == 0)
                dst = src + 32'($urandom_range(0, 6)) - 32'd3;
            else
                dst = 32'($urandom_range(0, 200));
            len = $urandom_range(1, 24);
            run_copy(src, dst, len, it % 2);
        end
    endtask

    task automatic test_max_length();
        randomize_mem();
        run_copy(32'd0, 32'd1, 255, 0);
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_length();
        test_start_ignored();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_max_length();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-copy initiator for the single-cycle CPU's data memory port. Given a source word address, a destination word address and a word count, it drives the memory's `read`/`write`/`address`/`write_data` pins and samples `read_data`, moving one word per two clocks. It sits between the CPU's control logic and the data memory, taking the memory port while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 32: width of memory word addresses.
- `DATA_W`, 32: width of a memory word.
- `LEN_W`, 8: width of the word-count input.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse, sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source word address, latched on accepted `start`.
- `dst_addr`  in  ADDR_W  first destination word address, latched on accepted `start`.
- `length`  in  LEN_W  number of words, latched on accepted `start`.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  DATA_W  running sum of copied words (see Configuration).
- `mem_read`  out  1  to memory `read`.
- `mem_write`  out  1  to memory `write`.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_write_data`  out  DATA_W  to memory `write_data`.
- `mem_read_data`  in  DATA_W  from memory `read_data` (combinational, same cycle).

## Operation
- States: IDLE, READ, WRITE, DONE. Moore outputs, decoded from registered state and counters only.
- IDLE: all memory outputs 0. `start`=1 latches `src_addr`, `dst_addr` and `length`, and clears the index `i`. `length`=0 -> DONE; otherwise -> READ.
- READ: `mem_read`=1, `mem_address`=src+i. At the clock edge, `mem_read_data` is captured into the data register -> WRITE.
- WRITE: `mem_write`=1, `mem_address`=dst+i, `mem_write_data`=data register. At the edge, `i` increments. If `i`+1 == length -> DONE, else -> READ.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- Address arithmetic is modulo 2^ADDR_W; src+i and dst+i wrap silently.
- `mem_read` and `mem_write` are never high in the same cycle.
- `start` outside IDLE is ignored. It is neither queued nor allowed to restart the transfer.
- Overlapping ranges are copied in ascending order. A destination below the source is therefore safe; a destination above the source in an overlapping range propagates already-written data. This is the defined behaviour.

## Timing
- Reset (synchronous) puts the block in IDLE. All outputs go to 0: `busy`, `done`, `mem_read`, `mem_write`, `mem_address`, `mem_write_data` and `checksum`. The data register, `i` and the latched inputs are also cleared.
- Reset mid-transfer aborts at the next edge. Words already written stay written. No `done` is produced.
- Latency: an accepted `start` at edge 0 gives READ in cycle 1. A transfer of N≥1 words occupies 2N cycles of `busy`, then one DONE cycle. `done` is high in cycle 2N+1.
- `length`=0: `done` is high in cycle 1 and `busy` never rises.
- A `start` held high during DONE is not accepted. The earliest new acceptance is the edge at the end of the IDLE cycle that follows DONE.
- Maximum transfer is 2^LEN_W−1 words.

## Configuration
- `MEM_COPY_DMA_CHECKSUM_EN` defined: `checksum` is cleared on accepted `start`. Each READ edge adds the captured word, modulo 2^DATA_W. The value holds after DONE until the next accepted `start` or `reset`.
- Not defined: `checksum` is tied to 0 and no adder is built. All other behaviour is identical.

## Test plan
- Reset, then copy: memory[0..3]=9, `start` with src=0, dst=8, len=4 -> `busy` high for cycles 1–8, memory[8..11]=9, `done` in cycle 9, `checksum`=36 (0 without the macro).
- len=0, `start` -> `done` in cycle 1, `busy` and `mem_write` never asserted, memory unchanged.
- `start` pulsed repeatedly during a len=2 transfer -> exactly one `done` pulse, and the addresses follow only the first request.
- src=2^ADDR_W−1, dst=16, len=2 -> READ addresses are 0xFFFFFFFF then 0x00000000, and memory[16..17] receives those words.
- `reset` asserted in cycle 3 of a len=4 copy -> all outputs 0 next cycle, memory[8] written, memory[9..11] untouched, no `done`.
- Protocol check throughout: `mem_read` & `mem_write` is never 1; `mem_write_data` equals the word read in the preceding READ cycle.
